// File: rtl/ysyx_23060136_wbu_csr_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060136_wbu_csr_ctrl_pkg
// Shared definitions for the WBU CSR sequencer: data/index widths, compacted
// CSR file indices, mstatus bit positions, request/FSM enums and the bundle
// of registered write/redirect outputs.
// ---------------------------------------------------------------------------
package ysyx_23060136_wbu_csr_ctrl_pkg;

    localparam int BITS_W = 64;
    localparam int CSR_W  = 3;

    // Compacted CSR file indices
    localparam logic [CSR_W-1:0] IDX_MSTATUS = 3'd0;
    localparam logic [CSR_W-1:0] IDX_MTVEC   = 3'd1;
    localparam logic [CSR_W-1:0] IDX_MEPC    = 3'd2;
    localparam logic [CSR_W-1:0] IDX_MCAUSE  = 3'd3;

    // mstatus bit positions
    localparam int MS_MIE    = 3;
    localparam int MS_MPIE   = 7;
    localparam int MS_MPP_LO = 11;
    localparam int MS_MPP_HI = 12;

    typedef enum logic [1:0] {
        REQ_CSRW  = 2'b00,
        REQ_ECALL = 2'b01,
        REQ_MRET  = 2'b10,
        REQ_RSVD  = 2'b11
    } req_type_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CSRW,
        ST_RD_ST,
        ST_E_WR,
        ST_E_ST,
        ST_M_WR,
        ST_NOP
    } state_e;

    // Everything the controller drives from flops, grouped so the next-value
    // logic can clear it with a single default.
    typedef struct packed {
        logic              wr_en_1;
        logic [CSR_W-1:0]  wr_idx_1;
        logic [BITS_W-1:0] wr_data_1;
        logic              wr_en_2;
        logic [CSR_W-1:0]  wr_idx_2;
        logic [BITS_W-1:0] wr_data_2;
        logic              redirect_valid;
        logic [BITS_W-1:0] redirect_pc;
        logic              illegal;
    } ctrl_out_t;

endpackage

// File: rtl/ysyx_23060136_wbu_mstatus_upd.sv
// ---------------------------------------------------------------------------
// ysyx_23060136_wbu_mstatus_upd
// Combinational mstatus rewrite for trap entry (ECALL) and trap return (MRET)
// on an M-mode-only core. Bits other than MIE/MPIE/MPP pass through.
//   old_st  in  BITS_W  current mstatus
//   is_mret in  1       1: MRET rule, 0: ECALL rule
//   new_st  out BITS_W  mstatus to write back
// ---------------------------------------------------------------------------
module ysyx_23060136_wbu_mstatus_upd
    import ysyx_23060136_wbu_csr_ctrl_pkg::*;
(
    input  logic [BITS_W-1:0] old_st,
    input  logic              is_mret,
    output logic [BITS_W-1:0] new_st
);

    // NOTE: new_st is fully assigned before any conditional override, so no latch is inferred.
    always_comb begin
        new_st = old_st;
        // Only M-mode exists, so the previous privilege is always M.
        new_st[MS_MPP_HI:MS_MPP_LO] = 2'b11;
        if (is_mret) begin
            new_st[MS_MIE]  = old_st[MS_MPIE];
            new_st[MS_MPIE] = 1'b1;
        end else begin
            new_st[MS_MPIE] = old_st[MS_MIE];
            new_st[MS_MIE]  = 1'b0;
        end
    end

endmodule

// File: rtl/ysyx_23060136_wbu_csr_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_23060136_wbu_csr_ctrl
// WBU CSR sequencer. Turns retired CSR events (CSRW, ECALL, MRET) into ordered
// read/modify/write sequences on the CSR file and issues the trap redirect.
//   clk, rst           clock, synchronous active-high reset
//   req_valid/ready    event handshake (ready only in IDLE)
//   req_type/pc/csr_idx/wdata/cause  event payload, latched at accept
//   rd_idx / rd_data   CSR file read port (combinational data)
//   wr_en/idx/data_1   CSR write channel 1 (priority)
//   wr_en/idx/data_2   CSR write channel 2
//   redirect_valid/pc  one-cycle fetch redirect
//   illegal            one-cycle pulse for reserved req_type
// ---------------------------------------------------------------------------
module ysyx_23060136_wbu_csr_ctrl
    import ysyx_23060136_wbu_csr_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_type,
    input  logic [BITS_W-1:0] req_pc,
    input  logic [CSR_W-1:0]  req_csr_idx,
    input  logic [BITS_W-1:0] req_wdata,
    input  logic [BITS_W-1:0] req_cause,
    output logic [CSR_W-1:0]  rd_idx,
    input  logic [BITS_W-1:0] rd_data,
    output logic              wr_en_1,
    output logic [CSR_W-1:0]  wr_idx_1,
    output logic [BITS_W-1:0] wr_data_1,
    output logic              wr_en_2,
    output logic [CSR_W-1:0]  wr_idx_2,
    output logic [BITS_W-1:0] wr_data_2,
    output logic              redirect_valid,
    output logic [BITS_W-1:0] redirect_pc,
    output logic              illegal
);

    state_e            state, state_nxt;
    ctrl_out_t         out_q, out_nxt;
    logic              ready_q;
    logic              accept;

    req_type_e         type_q;
    logic [BITS_W-1:0] pc_q;
    logic [BITS_W-1:0] cause_q;
    logic [BITS_W-1:0] st_q;
    logic [BITS_W-1:0] st_new;

    assign accept = req_valid && ready_q && (state == ST_IDLE);

    ysyx_23060136_wbu_mstatus_upd u_mstatus_upd (
        .old_st  (st_q),
        .is_mret (type_q == REQ_MRET),
        .new_st  (st_new)
    );

    // Read-port schedule. IDLE already presents mstatus, so mstatus is
    // captured at accept; that frees RD_ST's slot for mepc on MRET, which
    // lets the MRET write and redirect leave in the cycle after RD_ST.
    always_comb begin
        rd_idx = IDX_MSTATUS;
        case (state)
            ST_RD_ST: rd_idx = (type_q == REQ_MRET) ? IDX_MEPC : IDX_MSTATUS;
            ST_E_WR:  rd_idx = IDX_MTVEC;
            default:  rd_idx = IDX_MSTATUS;
        endcase
    end

    // Next state and next registered outputs. Outputs are zero unless the
    // state being entered drives them.
    always_comb begin
        state_nxt = state;
        out_nxt   = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (req_type_e'(req_type))
                        REQ_CSRW: begin
                            state_nxt         = ST_CSRW;
                            out_nxt.wr_en_1   = 1'b1;
                            out_nxt.wr_idx_1  = req_csr_idx;
                            out_nxt.wr_data_1 = req_wdata;
                        end
                        REQ_ECALL, REQ_MRET: state_nxt = ST_RD_ST;
                        default: begin
                            state_nxt       = ST_NOP;
                            out_nxt.illegal = 1'b1;
                        end
                    endcase
                end
            end
            ST_RD_ST: begin
                if (type_q == REQ_MRET) begin
                    // rd_data is mepc in this state.
                    state_nxt              = ST_M_WR;
                    out_nxt.wr_en_1        = 1'b1;
                    out_nxt.wr_idx_1       = IDX_MSTATUS;
                    out_nxt.wr_data_1      = st_new;
                    out_nxt.redirect_valid = 1'b1;
                    out_nxt.redirect_pc    = rd_data;
                end else begin
                    state_nxt         = ST_E_WR;
                    out_nxt.wr_en_1   = 1'b1;
                    out_nxt.wr_idx_1  = IDX_MEPC;
                    out_nxt.wr_data_1 = pc_q;
                    out_nxt.wr_en_2   = 1'b1;
                    out_nxt.wr_idx_2  = IDX_MCAUSE;
                    out_nxt.wr_data_2 = cause_q;
                end
            end
            ST_E_WR: begin
                // rd_data is mtvec; direct mode only, so drop the mode bits.
                state_nxt              = ST_E_ST;
                out_nxt.wr_en_1        = 1'b1;
                out_nxt.wr_idx_1       = IDX_MSTATUS;
                out_nxt.wr_data_1      = st_new;
                out_nxt.redirect_valid = 1'b1;
                out_nxt.redirect_pc    = rd_data & ~BITS_W'(3);
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state and output flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            out_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            out_q   <= out_nxt;
            ready_q <= (state_nxt == ST_IDLE);
        end
    end

    // NOTE: payload registers carry no reset; they are only read in states reached after an accept loads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            type_q  <= req_type_e'(req_type);
            pc_q    <= req_pc;
            cause_q <= req_cause;
            st_q    <= rd_data;
        end
    end

    assign req_ready      = ready_q;
    assign wr_en_1        = out_q.wr_en_1;
    assign wr_idx_1       = out_q.wr_idx_1;
    assign wr_data_1      = out_q.wr_data_1;
    assign wr_en_2        = out_q.wr_en_2;
    assign wr_idx_2       = out_q.wr_idx_2;
    assign wr_data_2      = out_q.wr_data_2;
    assign redirect_valid = out_q.redirect_valid;
    assign redirect_pc    = out_q.redirect_pc;
    assign illegal        = out_q.illegal;

endmodule

// File: tb/tb_ysyx_23060136_wbu_csr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060136_wbu_csr_ctrl
// Drives CSR events into the sequencer against a small CSR file, and checks
// per-cycle outputs and CSR contents against a reference of the event rules.
// ---------------------------------------------------------------------------
module tb_ysyx_23060136_wbu_csr_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_type;
    logic [63:0] req_pc;
    logic [2:0]  req_csr_idx;
    logic [63:0] req_wdata;
    logic [63:0] req_cause;
    logic [2:0]  rd_idx;
    logic [63:0] rd_data;
    logic        wr_en_1, wr_en_2;
    logic [2:0]  wr_idx_1, wr_idx_2;
    logic [63:0] wr_data_1, wr_data_2;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_23060136_wbu_csr_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_type       (req_type),
        .req_pc         (req_pc),
        .req_csr_idx    (req_csr_idx),
        .req_wdata      (req_wdata),
        .req_cause      (req_cause),
        .rd_idx         (rd_idx),
        .rd_data        (rd_data),
        .wr_en_1        (wr_en_1),
        .wr_idx_1       (wr_idx_1),
        .wr_data_1      (wr_data_1),
        .wr_en_2        (wr_en_2),
        .wr_idx_2       (wr_idx_2),
        .wr_data_2      (wr_data_2),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .illegal        (illegal)
    );

    // CSR file the DUT talks to: combinational read, channel 1 wins a tie.
    logic [63:0] csr_file [8] = '{default: 64'd0};
    always @(posedge clk) begin
        if (wr_en_2) csr_file[wr_idx_2] <= wr_data_2;
        if (wr_en_1) csr_file[wr_idx_1] <= wr_data_1;
    end
    assign rd_data = csr_file[rd_idx];

    // Reference CSR contents, updated only from the event rules.
    logic [63:0] ref_csr [8];

    function automatic logic [63:0] ref_ecall_st(logic [63:0] st);
        return (st & ~64'h1888) | (64'(st[3]) << 7) | 64'h1800;
    endfunction

    function automatic logic [63:0] ref_mret_st(logic [63:0] st);
        return (st & ~64'h1888) | (64'(st[7]) << 3) | 64'h1880;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_cycle(string tag,
                                logic e1, logic [2:0] i1, logic [63:0] d1,
                                logic e2, logic [2:0] i2, logic [63:0] d2,
                                logic rv, logic [63:0] rpc, logic ill, logic rdy);
        check({tag, ".wr_en_1"}, 64'(wr_en_1), 64'(e1));
        if (e1) begin
            check({tag, ".wr_idx_1"}, 64'(wr_idx_1), 64'(i1));
            check({tag, ".wr_data_1"}, wr_data_1, d1);
        end
        check({tag, ".wr_en_2"}, 64'(wr_en_2), 64'(e2));
        if (e2) begin
            check({tag, ".wr_idx_2"}, 64'(wr_idx_2), 64'(i2));
            check({tag, ".wr_data_2"}, wr_data_2, d2);
        end
        check({tag, ".redirect_valid"}, 64'(redirect_valid), 64'(rv));
        if (rv) check({tag, ".redirect_pc"}, redirect_pc, rpc);
        check({tag, ".illegal"}, 64'(illegal), 64'(ill));
        check({tag, ".req_ready"}, 64'(req_ready), 64'(rdy));
    endtask

    task automatic expect_idle(string tag, logic rdy);
        expect_cycle(tag, 1'b0, 3'd0, 64'd0, 1'b0, 3'd0, 64'd0, 1'b0, 64'd0, 1'b0, rdy);
    endtask

    task automatic compare_csr(string tag);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s.csr%0d", tag, i), csr_file[i], ref_csr[i]);
    endtask

    // Offer one event at the current negedge and follow it back to IDLE.
    task automatic run_event(logic [1:0] t, logic [63:0] pc, logic [2:0] idx,
                             logic [63:0] wd, logic [63:0] cause);
        logic [63:0] st;
        int n;
        req_valid   = 1'b1;
        req_type    = t;
        req_pc      = pc;
        req_csr_idx = idx;
        req_wdata   = wd;
        req_cause   = cause;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept.req_ready", 64'(req_ready), 64'd1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        st = ref_csr[0];
        @(negedge clk);
        req_valid = 1'b0;
        case (t)
            2'b00: begin
                expect_cycle("csrw", 1'b1, idx, wd, 1'b0, 3'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
                ref_csr[idx] = wd;
            end
            2'b01: begin
                expect_idle("ecall.rd_st", 1'b0);
                @(negedge clk);
                expect_cycle("ecall.e_wr", 1'b1, 3'd2, pc, 1'b1, 3'd3, cause,
                             1'b0, 64'd0, 1'b0, 1'b0);
                @(negedge clk);
                expect_cycle("ecall.e_st", 1'b1, 3'd0, ref_ecall_st(st), 1'b0, 3'd0, 64'd0,
                             1'b1, ref_csr[1] & ~64'd3, 1'b0, 1'b0);
                ref_csr[2] = pc;
                ref_csr[3] = cause;
                ref_csr[0] = ref_ecall_st(st);
            end
            2'b10: begin
                expect_idle("mret.rd_st", 1'b0);
                @(negedge clk);
                expect_cycle("mret.m_wr", 1'b1, 3'd0, ref_mret_st(st), 1'b0, 3'd0, 64'd0,
                             1'b1, ref_csr[2], 1'b0, 1'b0);
                ref_csr[0] = ref_mret_st(st);
            end
            default: begin
                expect_cycle("rsvd", 1'b0, 3'd0, 64'd0, 1'b0, 3'd0, 64'd0,
                             1'b0, 64'd0, 1'b1, 1'b0);
            end
        endcase
        @(negedge clk);
        expect_idle("event.done", 1'b1);
        compare_csr("event");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] st;
        for (int i = 0; i < 8; i++) ref_csr[i] = 64'd0;
        req_valid   = 1'b0;
        req_type    = 2'b00;
        req_pc      = 64'd0;
        req_csr_idx = 3'd0;
        req_wdata   = 64'd0;
        req_cause   = 64'd0;

        // Reset for two cycles
        rst = 1'b1;
        repeat (2) @(negedge clk);
        expect_idle("reset", 1'b0);
        check("reset.rd_idx", 64'(rd_idx), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset.ready_after", 64'(req_ready), 64'd1);

        // CSRW idx 3 = 0x55
        run_event(2'b00, 64'd0, 3'd3, 64'h55, 64'd0);

        // ECALL from known state
        run_event(2'b00, 64'd0, 3'd0, 64'ha00001808, 64'd0);
        run_event(2'b00, 64'd0, 3'd1, 64'h80000103, 64'd0);
        run_event(2'b01, 64'h80000010, 3'd0, 64'd0, 64'd11);
        check("ecall.mstatus", csr_file[0], 64'ha00001880);
        check("ecall.mepc", csr_file[2], 64'h80000010);
        check("ecall.mcause", csr_file[3], 64'hb);

        // MRET
        run_event(2'b00, 64'd0, 3'd2, 64'h80000014, 64'd0);
        run_event(2'b10, 64'd0, 3'd0, 64'd0, 64'd0);
        check("mret.mstatus", csr_file[0], 64'ha00001888);

        // Reserved type
        run_event(2'b11, 64'd0, 3'd0, 64'd0, 64'd0);

        // Busy backpressure: CSRW held valid from the cycle after ECALL accept
        st = ref_csr[0];
        req_valid = 1'b1;
        req_type  = 2'b01;
        req_pc    = 64'h80000020;
        req_cause = 64'd8;
        check("bp.ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_type    = 2'b00;
        req_csr_idx = 3'd5;
        req_wdata   = 64'hdeadbeef;
        expect_idle("bp.rd_st", 1'b0);
        @(negedge clk);
        expect_cycle("bp.e_wr", 1'b1, 3'd2, 64'h80000020, 1'b1, 3'd3, 64'd8,
                     1'b0, 64'd0, 1'b0, 1'b0);
        @(negedge clk);
        expect_cycle("bp.e_st", 1'b1, 3'd0, ref_ecall_st(st), 1'b0, 3'd0, 64'd0,
                     1'b1, ref_csr[1] & ~64'd3, 1'b0, 1'b0);
        @(negedge clk);
        expect_idle("bp.gap", 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        expect_cycle("bp.csrw", 1'b1, 3'd5, 64'hdeadbeef, 1'b0, 3'd0, 64'd0,
                     1'b0, 64'd0, 1'b0, 1'b0);
        @(negedge clk);
        expect_idle("bp.done", 1'b1);
        ref_csr[2] = 64'h80000020;
        ref_csr[3] = 64'd8;
        ref_csr[0] = ref_ecall_st(st);
        ref_csr[5] = 64'hdeadbeef;
        compare_csr("bp");

        // Reset asserted during E_WR
        req_valid = 1'b1;
        req_type  = 2'b01;
        req_pc    = 64'h80000040;
        req_cause = 64'd11;
        @(negedge clk);
        req_valid = 1'b0;
        expect_idle("rst.rd_st", 1'b0);
        @(negedge clk);
        expect_cycle("rst.e_wr", 1'b1, 3'd2, 64'h80000040, 1'b1, 3'd3, 64'd11,
                     1'b0, 64'd0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        expect_idle("rst.during", 1'b0);
        rst = 1'b0;
        @(negedge clk);
        expect_idle("rst.after", 1'b1);
        ref_csr[2] = 64'h80000040;
        ref_csr[3] = 64'd11;
        compare_csr("rst");

        // Randomized events
        for (int k = 0; k < 60; k++) begin
            logic [1:0]  t;
            logic [2:0]  idx;
            logic [63:0] pc, wd, cause;
            t     = 2'($urandom_range(0, 3));
            idx   = 3'($urandom_range(0, 7));
            pc    = {$urandom, $urandom};
            wd    = {$urandom, $urandom};
            cause = {$urandom, $urandom};
            run_event(t, pc, idx, wd, cause);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_23060136_wbu_csr_ctrl.md
Name: ysyx_23060136_wbu_csr_ctrl

Overview:
Sequencer in WBU that owns the two write channels and a dedicated read port of the CSR file. It turns retired CSR-side events (plain CSR write, ECALL trap entry, MRET trap return) into ordered multi-cycle read/modify/write sequences. It also emits a PC redirect for traps. Write outputs connect directly to the CSR file's channel-1/channel-2 write-enable, index and data inputs.

Parameters:
BITS_W, 64, CSR data width
CSR_W, 3, CSR index width (compacted CSR file index)
IDX_MSTATUS, 0, compacted index of mstatus
IDX_MTVEC, 1, compacted index of mtvec
IDX_MEPC, 2, compacted index of mepc
IDX_MCAUSE, 3, compacted index of mcause

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  event offered by WBU
req_ready  out  1  controller can accept (high only in IDLE)
req_type  in  2  00 CSRW, 01 ECALL, 10 MRET, 11 reserved
req_pc  in  BITS_W  PC of retiring instruction
req_csr_idx  in  CSR_W  target index for CSRW
req_wdata  in  BITS_W  write data for CSRW
req_cause  in  BITS_W  mcause value for ECALL
rd_idx  out  CSR_W  read-port index into CSR file
rd_data  in  BITS_W  combinational read data for rd_idx
wr_en_1 / wr_idx_1 / wr_data_1  out  1 / CSR_W / BITS_W  CSR write channel 1 (priority channel)
wr_en_2 / wr_idx_2 / wr_data_2  out  1 / CSR_W / BITS_W  CSR write channel 2
redirect_valid  out  1  one-cycle pulse: fetch must jump
redirect_pc  out  BITS_W  jump target, valid with redirect_valid
illegal  out  1  one-cycle pulse on reserved req_type

Behaviour:
- Handshake: event accepted on the cycle where req_valid & req_ready. Request fields are latched at accept. req_ready=0 in every non-IDLE state; offers made while busy are ignored and must be held by WBU.
- All wr_*, redirect_*, illegal are registered. Reset: state=IDLE, all outputs 0, req_ready=1 one cycle after rst deasserts, rd_idx=IDX_MSTATUS.
- States: IDLE, CSRW, RD_ST, E_WR, E_ST, M_WR, NOP.
- IDLE --accept CSRW--> CSRW. In CSRW: wr_en_1=1, idx=latched idx, data=latched wdata. Next state IDLE. Latency: write visible to CSR file at the edge ending CSRW.
- IDLE --accept ECALL/MRET--> RD_ST. In RD_ST: rd_idx=IDX_MSTATUS; latch rd_data as st.
- ECALL, RD_ST -> E_WR:
  - ch1 writes mepc=latched pc; ch2 writes mcause=latched cause.
  - rd_idx=IDX_MTVEC; latch rd_data & ~3 as target.
- E_WR -> E_ST:
  - ch1 writes mstatus = st with MPIE(bit7)=st[3], MIE(bit3)=0, MPP(12:11)=2'b11.
  - redirect_valid=1, redirect_pc=target.
  - Next state IDLE.
- MRET, RD_ST -> M_WR:
  - rd_idx=IDX_MEPC; latch rd_data.
  - ch1 writes mstatus = st with MIE=st[7], MPIE=1, MPP=2'b11 (M-only core).
  - redirect_valid=1, redirect_pc=latched mepc.
  - Next state IDLE.
- Reserved type: IDLE -> NOP. illegal=1 for one cycle, no writes, next state IDLE.
- The controller never asserts both channels to the same index. If the CSR file sees equal indices, ch1 wins (CSR file rule).
- Other mstatus bits pass through unmodified. Arithmetic is bitwise only; no width extension is needed.
- rst in any state: next cycle IDLE, outputs cleared, partial sequence abandoned. Already-committed writes persist.
- Cycle counts from accept to return to IDLE: CSRW 1, ECALL 3, MRET 2, reserved 1.

Decomposition:
- Shared package (DEFINES): req_type enum (CSRW/ECALL/MRET/RSVD), FSM state enum, mstatus bit positions (MIE=3, MPIE=7, MPP_LO=11, MPP_HI=12), CSR index constants.
- One natural sub-module: ysyx_23060136_wbu_mstatus_upd. It is combinational; inputs old mstatus and is_mret, output new mstatus. It is unit-testable in isolation.

Test Plan:
- Reset/CSRW: rst 2 cycles, then CSRW idx=3 wdata=0x55. Required: wr_en_1=1, idx 3, data 0x55 exactly one cycle after accept; req_ready=0 in that cycle, 1 the next.
- ECALL: mstatus=0xa00001808, mtvec=0x80000103, pc=0x80000010, cause=11.
  - E_WR cycle: ch1 mepc=0x80000010, ch2 mcause=0xb.
  - Next cycle: mstatus write 0xa00001880; redirect_valid=1, redirect_pc=0x80000100.
- MRET: mstatus=0xa00001880, mepc=0x80000014. Required: mstatus write 0xa00001888 and redirect_pc=0x80000014 in the same cycle, 2 cycles after accept.
- Busy backpressure: ECALL accepted, then CSRW held valid. Required: CSRW accepted only in the cycle after E_ST, and its write follows the mstatus write with no overlap.
- Reset mid-ECALL: assert rst during E_WR. Required: no E_ST write, no redirect, all outputs 0 the next cycle, req_ready=1 after release.
- Reserved type 11: illegal pulses 1 cycle, no wr_en_1/wr_en_2, back in IDLE.
